delay_seq_ctrl: RTL and testbench

//  Sequencer for the sigdelay datapath (address counter + dual-port sample RAM).

---
 rtl/delay_seq_ctrl_if.sv | 36 +++
 rtl/delay_seq_ctrl.sv | 119 +++++++++++
 tb/tb_delay_seq_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/delay_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : delay_seq_ctrl_if
// Description : Control/status bundle between the audio front end and the
//               sigdelay sequencer.
//               master : front end (drives start/stop/tick/delay controls)
//               slave  : sequencer (drives RAM strobes, offset, status)
// Revision    : 1.0 - initial release
// ============================================================================
interface delay_seq_ctrl_if #(
  parameter int A_WIDTH = 9
);
  logic               start;
  logic               stop;
  logic               sample_tick;
  logic [A_WIDTH-1:0] delay_in;
  logic               delay_ld;
  logic               wr_en;
  logic               rd_en;
  logic               en;
  logic [A_WIDTH-1:0] incr;
  logic [A_WIDTH-1:0] offset;
  logic               out_valid;
  logic [1:0]         state;

  modport master (
    output start, stop, sample_tick, delay_in, delay_ld,
    input  wr_en, rd_en, en, incr, offset, out_valid, state
  );

  modport slave (
    input  start, stop, sample_tick, delay_in, delay_ld,
    output wr_en, rd_en, en, incr, offset, out_valid, state
  );
endinterface
`default_nettype wire

// File: rtl/delay_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : delay_seq_ctrl
// Description : Sequencer for the sigdelay datapath. Converts per-sample
//               strobes into RAM write/read and counter-advance pulses, holds
//               the delay setting, and withholds reads until enough history
//               has been written for the requested delay.
// Ports       : clk  - clock
//               rst  - asynchronous reset, active-high
//               bus  - delay_seq_ctrl_if.slave (controls in, strobes/status out)
// Revision    : 1.0 - initial release
// ============================================================================
module delay_seq_ctrl #(
  parameter int A_WIDTH   = 9,
  parameter int DEF_DELAY = 100
) (
  input  wire logic         clk,
  input  wire logic         rst,
  delay_seq_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PRIME = 2'b01,
    S_RUN   = 2'b10
  } state_e;

  localparam logic [A_WIDTH-1:0] FILL_MAX = '1;
  localparam logic [A_WIDTH-1:0] DEF_OFS  = A_WIDTH'(DEF_DELAY);
  localparam logic [A_WIDTH-1:0] ONE      = A_WIDTH'(1);

  state_e             state_q, state_d;
  logic [A_WIDTH-1:0] offset_q, offset_d;
  logic [A_WIDTH-1:0] fill_q, fill_d;
  logic               wr_en_q, wr_en_d;
  logic               rd_en_q, rd_en_d;
  logic               en_q, en_d;
  logic               out_valid_q, out_valid_d;
  logic [A_WIDTH-1:0] fill_inc;

  // Saturating history count: once the RAM is full it stays "full".
  assign fill_inc = (fill_q == FILL_MAX) ? fill_q : fill_q + ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      offset_q    <= DEF_OFS;
      fill_q      <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      en_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      offset_q    <= offset_d;
      fill_q      <= fill_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      en_q        <= en_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    fill_d      = fill_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    en_d        = 1'b0;
    // RAM read data appears one cycle after the read strobe.
    out_valid_d = rd_en_q;

    // A zero delay would read the address being written; clamp to 1.
    if (bus.delay_ld) begin
      offset_d = (bus.delay_in == '0) ? ONE : bus.delay_in;
    end

    case (state_q)
      S_IDLE: begin
        fill_d = '0;
        if (bus.start && !bus.stop) begin
          state_d = S_PRIME;
        end
      end
      S_PRIME, S_RUN: begin
        if (bus.stop) begin
          state_d = S_IDLE;
          fill_d  = '0;
        end else if (bus.sample_tick) begin
          wr_en_d = 1'b1;
          en_d    = 1'b1;
          // Read only when the sample offset ticks back was really written.
          // Using the pre-increment count keeps this true at saturation.
          rd_en_d = (state_q == S_RUN) && (fill_q >= offset_q);
          fill_d  = fill_inc;
          state_d = (fill_inc >= offset_q) ? S_RUN : S_PRIME;
        end else if ((state_q == S_RUN) && (fill_q < offset_q)) begin
          // Delay raised beyond the available history: refill first.
          state_d = S_PRIME;
        end
      end
      default: begin
        state_d = S_IDLE;
        fill_d  = '0;
      end
    endcase
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.en        = en_q;
  assign bus.incr      = ONE;
  assign bus.offset    = offset_q;
  assign bus.out_valid = out_valid_q;
  assign bus.state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_delay_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_delay_seq_ctrl
// Description : Self-checking bench for delay_seq_ctrl. A reference model of
//               the sequencing rules produces the expected output bundle for
//               every clock; a separate monitor compares it against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_delay_seq_ctrl;
  localparam int A_WIDTH   = 9;
  localparam int DEF_DELAY = 100;
  localparam int HIST_MAX  = (1 << A_WIDTH) - 1;
  localparam int P_IDLE = 0, P_PRIME = 1, P_RUN = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  delay_seq_ctrl_if #(.A_WIDTH(A_WIDTH)) bus ();

  delay_seq_ctrl #(.A_WIDTH(A_WIDTH), .DEF_DELAY(DEF_DELAY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit wr;
    bit rd;
    bit en;
    bit ov;
    int offset;
    int state;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Reference model: phase, samples written since start, active delay.
  int phase   = P_IDLE;
  int history = 0;
  int delay   = DEF_DELAY;
  bit read_prev = 0;

  function automatic void model_step(bit r, bit st, bit sp, bit tk, bit ld, int din);
    exp_t e;
    int   new_delay;
    e = '{wr: 0, rd: 0, en: 0, ov: 0, offset: 0, state: 0};
    if (r) begin
      phase = P_IDLE; history = 0; delay = DEF_DELAY; read_prev = 0;
      e.offset = DEF_DELAY; e.state = P_IDLE;
      exp_q.push_back(e);
      return;
    end
    e.ov = read_prev;
    new_delay = ld ? ((din == 0) ? 1 : din) : delay;
    if (phase == P_IDLE) begin
      history = 0;
      if (st && !sp) phase = P_PRIME;
    end else if (sp) begin
      phase = P_IDLE;
      history = 0;
    end else if (tk) begin
      e.wr = 1;
      e.en = 1;
      // Delayed sample exists if at least 'delay' samples were already stored.
      e.rd = (phase == P_RUN) && (history >= delay);
      history = (history < HIST_MAX) ? history + 1 : HIST_MAX;
      phase = (history >= delay) ? P_RUN : P_PRIME;
    end else if (phase == P_RUN && history < delay) begin
      phase = P_PRIME;
    end
    delay    = new_delay;
    e.offset = delay;
    e.state  = phase;
    read_prev = e.rd;
    exp_q.push_back(e);
  endfunction

  task automatic cyc(input bit st, input bit sp, input bit tk, input bit ld, input int d);
    bus.start       = st;
    bus.stop        = sp;
    bus.sample_tick = tk;
    bus.delay_ld    = ld;
    bus.delay_in    = A_WIDTH'(d);
    @(posedge clk);
    model_step(rst, st, sp, tk, ld, d);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic check(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Monitor: compare the DUT against the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (bus.wr_en !== e.wr || bus.rd_en !== e.rd || bus.en !== e.en ||
            bus.out_valid !== e.ov || int'(bus.incr) != 1 ||
            int'(bus.offset) != e.offset || int'(bus.state) != e.state) begin
          n_miss++;
          $display("FAIL outputs @%0t: got wr=%0b rd=%0b en=%0b ov=%0b incr=%0d ofs=%0d st=%0d, want wr=%0b rd=%0b en=%0b ov=%0b incr=1 ofs=%0d st=%0d",
                   $time, bus.wr_en, bus.rd_en, bus.en, bus.out_valid, bus.incr,
                   bus.offset, bus.state, e.wr, e.rd, e.en, e.ov, e.offset, e.state);
        end
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

  initial begin
    bus.start = 0; bus.stop = 0; bus.sample_tick = 0; bus.delay_ld = 0; bus.delay_in = '0;
    rst = 1'b1;
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    rst = 1'b0;
    idle(2);

    // Delay 4, ticks every third cycle.
    cyc(0, 0, 0, 1, 4);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1, 0, 0);
      idle(2);
    end
    cyc(0, 1, 0, 0, 0);
    idle(2);

    // Zero delay clamps to 1.
    cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 0, 0);
      idle(1);
    end
    cyc(0, 1, 0, 0, 0);

    // Raise delay in RUN, then lower it again.
    cyc(0, 0, 0, 1, 4);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 10);
    idle(2);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 1, 0, 0);
      idle(1);
    end
    cyc(0, 0, 1, 1, 3);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);

    // start+stop together, in RUN (with a tick) and from IDLE.
    cyc(1, 1, 1, 0, 0);
    idle(1);
    cyc(1, 1, 1, 0, 0);
    idle(1);

    // Maximum delay with a tick every cycle: saturation.
    cyc(0, 0, 0, 1, HIST_MAX);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);

    // Randomized traffic.
    cyc(1, 0, 0, 1, 3);
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 59) == 0),
          ($urandom_range(0, 1) == 1), ($urandom_range(0, 14) == 0),
          int'($urandom_range(0, 15)));
    end
    cyc(0, 1, 0, 0, 0);

    // Asynchronous reset in the middle of RUN.
    cyc(0, 0, 0, 1, 2);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0);
    #2;
    rst = 1'b1;
    model_step(1, 0, 0, 0, 0, 0);
    void'(exp_q.pop_back());
    #1;
    check("async_rst wr_en", int'(bus.wr_en), 0);
    check("async_rst en", int'(bus.en), 0);
    check("async_rst rd_en", int'(bus.rd_en), 0);
    check("async_rst out_valid", int'(bus.out_valid), 0);
    check("async_rst offset", int'(bus.offset), DEF_DELAY);
    check("async_rst state", int'(bus.state), P_IDLE);
    @(negedge clk);
    cyc(0, 0, 1, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
    idle(3);
    @(negedge clk);

    if (exp_q.size() != 0) check("scoreboard drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
`default_nettype wire
